bit_serial_adder: RTL
=====================

// Module: bit_serial_adder
//
// PURPOSE
// - Sequential WIDTH-bit adder built around a one-bit full-adder cell.
// - Accepts two operands plus carry-in through a valid/ready handshake.
// - Adds one bit per clock, LSB first, and keeps the carry in a register between bits.
// - Returns the sum and carry-out through a valid/ready handshake.
// - Serves as the multi-bit stage built on top of the single-bit full adder with enable.
//
// PARAMETERS
// - WIDTH  default 8  operand/sum width in bits; legal range >= 1
//
// PORTS
// - clk        input   1      rising-edge clock
// - rst        input   1      synchronous, active-high reset
// - in_valid   input   1      a, b and cin are valid
// - in_ready   output  1      block can accept an operand set
// - a          input   WIDTH  operand A
// - b          input   WIDTH  operand B
// - cin        input   1      carry-in to bit 0
// - out_valid  output  1      sum and cout are valid
// - out_ready  input   1      consumer accepts the result
// - sum        output  WIDTH  (a + b + cin) mod 2^WIDTH
// - cout       output  1      carry out of bit WIDTH-1
//
// BEHAVIOUR
// - Reset: when rst is high at a clock edge:
//   - state goes to IDLE;
//   - shift registers, carry register and bit counter clear to 0;
//   - out_valid=0, sum=0, cout=0.
//   - in_ready=0 while rst is high; it goes to 1 in the first cycle after reset is released.
// - Reset wins over every other event, including mid-ADD and mid-DONE; any partial result is discarded.
// - FSM states: IDLE, ADD, DONE.
//   - IDLE: in_ready=1. On an edge with in_valid=1:
//     - latch a into a_sh, b into b_sh, cin into the carry register;
//     - clear bit_cnt;
//     - go to ADD.
//   - ADD: in_ready=0; the full-adder cell is enabled. Each edge:
//     - sum bit = a_sh[0]^b_sh[0]^carry;
//     - carry <= majority(a_sh[0], b_sh[0], carry);
//     - a_sh and b_sh shift right by 1;
//     - the sum bit shifts into the MSB of sum_sh;
//     - bit_cnt increments.
//     - On the edge that processes bit WIDTH-1: go to DONE, with sum <= final sum_sh and cout <= final carry.
//   - DONE: out_valid=1.
//     - sum and cout hold stable until the transfer.
//     - On an edge with out_ready=1: go to IDLE and drop out_valid.
//     - A new operand set can be accepted in the cycle after the transfer; there is no overlap.
// - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//   - Throughput: at most one add per WIDTH+2 cycles when out_ready is held at 1.
// - in_valid while state is not IDLE: ignored; operands are not sampled and no state changes.
// - out_ready while out_valid=0: ignored.
// - sum is all zeros from reset until the first completed add. Outside DONE, sum holds the last result.
// - bit_cnt width is $clog2(WIDTH+1). WIDTH=1 gives one ADD cycle.
// - Arithmetic is unsigned. Overflow is reported only through cout; nothing saturates.
//
// TESTING
// - WIDTH=8, a=8'h00, b=8'h00, cin=0 -> out_valid 8 edges after accept; sum=8'h00, cout=0.
// - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (carry ripples through all 8 bit-cycles).
// - a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Hold out_ready=0 for 5 cycles:
//   - out_valid stays 1; sum and cout stay stable; in_ready stays 0.
//   - Assert out_ready: IDLE and in_ready=1 next cycle.
// - While in ADD, present in_valid=1 with a=8'h11 -> ignored; the in-flight result is unchanged.
// - Assert rst for 1 cycle at bit-cycle 4 of a=8'h3C, b=8'h0F:
//   - out_valid=0, sum=0, cout=0 and in_ready=0 while rst=1; in_ready=1 the cycle after.
//   - The next add, 8'h01+8'h01 cin0, gives sum=8'h02, cout=0.
// - WIDTH=1, all 8 (a, b, cin) combinations -> sum/cout match the full-adder truth table, 1 edge latency each.

Source files
------------

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit unsigned adder that processes one bit per clock, LSB first,
// through a single full-adder cell with enable. Carry lives in a register between bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a, b, cin are valid          in_ready   block can accept an operand set
//   a, b       WIDTH-bit operands           cin        carry into bit 0
//   out_valid  sum/cout are valid           out_ready  consumer accepts the result
//   sum        (a + b + cin) mod 2^WIDTH    cout       carry out of bit WIDTH-1
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  sum_sh_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              cout_q;
    logic              out_valid_q;
    logic [CntW-1:0]   bit_cnt_q;

    // Full-adder cell, active only in ADD.
    logic             fa_en;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_bit_msb;
    logic [WIDTH-1:0] sum_sh_d;

    always_comb begin
        fa_en    = (state_q == StAdd);
        fa_sum   = fa_en & (a_sh_q[0] ^ b_sh_q[0] ^ carry_q);
        fa_carry = fa_en & ((a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                            (b_sh_q[0] & carry_q));
        // Built this way so WIDTH=1 needs no zero-width slice.
        sum_bit_msb            = '0;
        sum_bit_msb[WIDTH-1]   = fa_sum;
        sum_sh_d               = (sum_sh_q >> 1) | sum_bit_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_sh_q    <= a;
                        b_sh_q    <= b;
                        carry_q   <= cin;
                        bit_cnt_q <= '0;
                        state_q   <= StAdd;
                    end
                end
                StAdd: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    carry_q   <= fa_carry;
                    sum_sh_q  <= sum_sh_d;
                    bit_cnt_q <= bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == LastBit) begin
                        sum_q       <= sum_sh_d;
                        cout_q      <= fa_carry;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Held low during reset so nothing is offered to the producer until release.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
